spike_rate_decoder: RTL and testbench

//   Receive end of a neuron spike line. Turns a spike train back into numbers: spike count
//   per programmable window (rate) and the latest inter-spike interval (ISI).

---
 rtl/snn_pkg.sv | 14 +
 rtl/spike_rate_decoder_if.sv | 29 ++
 rtl/spike_rate_decoder_sat_counter.sv | 31 +++
 rtl/spike_rate_decoder.sv | 136 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-neuron blocks.
// Used by the lif-side blocks and the spike decoder.
package snn_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   localparam int SNN_WIN_W = 8;
   localparam int SNN_CNT_W = 5;
   localparam int SNN_ISI_W = 8;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike decoder: valid/ready plus rate and ISI.
// master drives out_valid/rate/isi; slave drives out_ready.
interface spike_rate_decoder_if
   import snn_pkg::*;
#(
   parameter int CNT_W = SNN_CNT_W,
   parameter int ISI_W = SNN_ISI_W
);

   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] rate;
   logic [ISI_W-1:0] isi;

   modport master (
      output out_valid,
      output rate,
      output isi,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  rate,
      input  isi,
      output out_ready
   );

endinterface

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter: clr wins over inc, holds at all-ones.
// Ports: clk, reset (async active-low), clr, inc, q (value), nxt (q plus inc, saturated).
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic [W-1:0] nxt
);

   logic [W-1:0] cnt_q;

   // nxt ignores clr so the owner can capture the value a
   // clearing cycle would have reached.
   assign nxt = (inc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
   assign q   = cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= nxt;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: spike count per programmable window and latest ISI.
// Ports: clk, reset (async active-low), enable, spike, win_len, res_if (result
// channel, master), overrun (sticky drop flag), busy (counting).
module spike_rate_decoder
   import snn_pkg::*;
#(
   parameter int WIN_W = SNN_WIN_W,
   parameter int CNT_W = SNN_CNT_W,
   parameter int ISI_W = SNN_ISI_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 spike,
   input  logic [WIN_W-1:0]     win_len,
   spike_rate_decoder_if.master res_if,
   output logic                 overrun,
   output logic                 busy
);

   state_e           state_q, state_d;
   logic             start, active;
   logic             edge_q;
   logic             ev, win_end, load;
   logic [WIN_W-1:0] len_q, win_cnt_q, len_smp;
   logic             seen_q;
   logic [ISI_W-1:0] isi_last_q, isi_fin;
   logic [ISI_W-1:0] tmr_q, tmr_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_fin;
   logic             valid_q, overrun_q;
   logic [CNT_W-1:0] rate_q;
   logic [ISI_W-1:0] isi_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (enable)  state_d = COUNT;
         COUNT: if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      start  = (state_q == IDLE) && enable;
      active = (state_q == COUNT) && enable;
      busy   = (state_q == COUNT);
   end

   assign ev      = active && spike && !edge_q;
   assign win_end = active && (win_cnt_q == len_q);
   assign len_smp = (win_len == '0) ? WIN_W'(1) : win_len;

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (start || win_end),
      .inc   (ev),
      .q     (cnt_q),
      .nxt   (cnt_fin)
   );

   sat_counter #(.W(ISI_W)) u_tmr (
      .clk   (clk),
      .reset (reset),
      .clr   (start || ev),
      .inc   (active),
      .q     (tmr_q),
      .nxt   (tmr_nxt)
   );

   // Interval ends on this cycle's event: timer+1, saturated.
   assign isi_fin = (ev && seen_q) ? tmr_nxt : isi_last_q;
   assign load    = win_end && (!valid_q || res_if.out_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_q     <= 1'b0;
         len_q      <= '0;
         win_cnt_q  <= '0;
         seen_q     <= 1'b0;
         isi_last_q <= '0;
      end else begin
         edge_q <= spike;
         if (start) begin
            len_q      <= len_smp;
            win_cnt_q  <= WIN_W'(1);
            seen_q     <= 1'b0;
            isi_last_q <= '0;
         end else if (active) begin
            if (win_end) begin
               len_q     <= len_smp;
               win_cnt_q <= WIN_W'(1);
            end else begin
               win_cnt_q <= win_cnt_q + 1'b1;
            end
            if (ev) begin
               seen_q     <= 1'b1;
               isi_last_q <= isi_fin;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         rate_q    <= '0;
         isi_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (load) begin
            valid_q <= 1'b1;
            rate_q  <= cnt_fin;
            isi_q   <= isi_fin;
         end else if (valid_q && res_if.out_ready) begin
            valid_q <= 1'b0;
         end
         if (start) begin
            overrun_q <= 1'b0;
         end else if (win_end && valid_q && !res_if.out_ready) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign res_if.out_valid = valid_q;
   assign res_if.rate      = rate_q;
   assign res_if.isi       = isi_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: reset, rate/ISI, held spikes,
// backpressure, saturation, enable drop, zero window length.
module tb_spike_rate_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       spike;
   logic [7:0] win_len;
   logic       overrun;
   logic       busy;
   int         checks = 0;
   int         errors = 0;

   spike_rate_decoder_if #(.CNT_W(5), .ISI_W(8)) bus ();

   spike_rate_decoder #(
      .WIN_W (8),
      .CNT_W (5),
      .ISI_W (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .spike   (spike),
      .win_len (win_len),
      .res_if  (bus.master),
      .overrun (overrun),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      enable = 1'b0;
      spike  = 1'b0;
      step();
   endtask

   task automatic start(input logic [7:0] len);
      win_len = len;
      enable  = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      enable        = 1'b0;
      spike         = 1'b0;
      win_len       = 8'd8;
      bus.out_ready = 1'b0;
      step();
      step();
      checks++;
      if ({bus.out_valid, bus.rate, bus.isi, overrun, busy} !== 16'h0) begin
         errors++;
         $display("FAIL reset_init: got v=%0b r=%0d i=%0d ov=%0b b=%0b, exp all 0",
                  bus.out_valid, bus.rate, bus.isi, overrun, busy);
      end
      reset = 1'b1;
      step();
      start(8'd4);
      for (int c = 1; c <= 4; c++) begin
         spike = (c == 1);
         step();
      end
      spike = 1'b0;
      checks++;
      if ({bus.out_valid, bus.rate} !== {1'b1, 5'd1}) begin
         errors++;
         $display("FAIL reset_pre: got v=%0b r=%0d, exp v=1 r=1",
                  bus.out_valid, bus.rate);
      end
      step();
      step();
      reset  = 1'b0;
      enable = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.rate, bus.isi, overrun, busy} !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid: got v=%0b r=%0d i=%0d ov=%0b b=%0b, exp all 0",
                  bus.out_valid, bus.rate, bus.isi, overrun, busy);
      end
      step();
      reset = 1'b1;
      for (int c = 0; c < 3; c++) step();
      checks++;
      if ({bus.out_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_after: got v=%0b b=%0b, exp 0 0",
                  bus.out_valid, busy);
      end
      bus.out_ready = 1'b1;
      start(8'd4);
      step();
      step();
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_early: got v=%0b, exp 0", bus.out_valid);
      end
      step();
      checks++;
      if ({bus.out_valid, bus.rate, bus.isi} !== {1'b1, 5'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_win: got v=%0b r=%0d i=%0d, exp 1 0 0",
                  bus.out_valid, bus.rate, bus.isi);
      end
   endtask

   task automatic test_rate_isi();
      bus.out_ready = 1'b1;
      go_idle();
      start(8'd8);
      for (int c = 1; c <= 8; c++) begin
         spike = (c == 1 || c == 3 || c == 5);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rate_early c=%0d: got v=%0b, exp 0", c, bus.out_valid);
         end
         step();
      end
      spike = 1'b0;
      checks++;
      if ({bus.out_valid, bus.rate, bus.isi} !== {1'b1, 5'd3, 8'd2}) begin
         errors++;
         $display("FAIL rate_end: got v=%0b r=%0d i=%0d, exp 1 3 2",
                  bus.out_valid, bus.rate, bus.isi);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rate_drop: got v=%0b, exp 0", bus.out_valid);
      end
   endtask

   task automatic test_held();
      bus.out_ready = 1'b1;
      go_idle();
      start(8'd8);
      for (int c = 1; c <= 16; c++) begin
         spike = (c >= 2 && c <= 10);
         step();
         if (c == 8) begin
            checks++;
            if ({bus.out_valid, bus.rate, bus.isi} !== {1'b1, 5'd1, 8'd0}) begin
               errors++;
               $display("FAIL held_w1: got v=%0b r=%0d i=%0d, exp 1 1 0",
                        bus.out_valid, bus.rate, bus.isi);
            end
         end
         if (c == 16) begin
            checks++;
            if ({bus.out_valid, bus.rate, bus.isi} !== {1'b1, 5'd0, 8'd0}) begin
               errors++;
               $display("FAIL held_w2: got v=%0b r=%0d i=%0d, exp 1 0 0",
                        bus.out_valid, bus.rate, bus.isi);
            end
         end
      end
      spike = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b1;
      go_idle();
      bus.out_ready = 1'b0;
      start(8'd4);
      for (int c = 1; c <= 8; c++) begin
         spike = (c == 1 || c == 3 || c == 5);
         step();
         if (c == 4) begin
            checks++;
            if ({bus.out_valid, bus.rate, bus.isi, overrun} !== {1'b1, 5'd2, 8'd2, 1'b0}) begin
               errors++;
               $display("FAIL bp_w1: got v=%0b r=%0d i=%0d ov=%0b, exp 1 2 2 0",
                        bus.out_valid, bus.rate, bus.isi, overrun);
            end
         end
      end
      spike = 1'b0;
      checks++;
      if ({bus.out_valid, bus.rate, bus.isi, overrun} !== {1'b1, 5'd2, 8'd2, 1'b1}) begin
         errors++;
         $display("FAIL bp_w2: got v=%0b r=%0d i=%0d ov=%0b, exp 1 2 2 1",
                  bus.out_valid, bus.rate, bus.isi, overrun);
      end
      bus.out_ready = 1'b1;
      step();
      checks++;
      if ({bus.out_valid, overrun} !== 2'b01) begin
         errors++;
         $display("FAIL bp_accept: got v=%0b ov=%0b, exp 0 1",
                  bus.out_valid, overrun);
      end
      bus.out_ready = 1'b0;
      go_idle();
      start(8'd4);
      for (int c = 1; c <= 4; c++) begin
         spike = (c == 2);
         step();
      end
      checks++;
      if ({bus.out_valid, bus.rate, bus.isi, overrun} !== {1'b1, 5'd1, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL bp_wa: got v=%0b r=%0d i=%0d ov=%0b, exp 1 1 0 0",
                  bus.out_valid, bus.rate, bus.isi, overrun);
      end
      for (int c = 1; c <= 4; c++) begin
         spike         = (c == 1 || c == 3);
         bus.out_ready = (c == 4);
         step();
         if (c == 2) begin
            checks++;
            if ({bus.out_valid, bus.rate, bus.isi} !== {1'b1, 5'd1, 8'd0}) begin
               errors++;
               $display("FAIL bp_hold: got v=%0b r=%0d i=%0d, exp 1 1 0",
                        bus.out_valid, bus.rate, bus.isi);
            end
         end
      end
      spike         = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if ({bus.out_valid, bus.rate, bus.isi, overrun} !== {1'b1, 5'd2, 8'd2, 1'b0}) begin
         errors++;
         $display("FAIL bp_swap: got v=%0b r=%0d i=%0d ov=%0b, exp 1 2 2 0",
                  bus.out_valid, bus.rate, bus.isi, overrun);
      end
   endtask

   task automatic test_saturation();
      bus.out_ready = 1'b1;
      go_idle();
      start(8'd100);
      for (int c = 1; c <= 800; c++) begin
         spike = (c <= 100 && (c % 2) == 1) || c == 401 || c == 701;
         step();
         if (c == 100) begin
            checks++;
            if ({bus.out_valid, bus.rate, bus.isi} !== {1'b1, 5'd31, 8'd2}) begin
               errors++;
               $display("FAIL sat_rate: got v=%0b r=%0d i=%0d, exp 1 31 2",
                        bus.out_valid, bus.rate, bus.isi);
            end
         end
         if (c == 500 || c == 800) begin
            checks++;
            if ({bus.out_valid, bus.rate, bus.isi} !== {1'b1, 5'd1, 8'd255}) begin
               errors++;
               $display("FAIL sat_isi c=%0d: got v=%0b r=%0d i=%0d, exp 1 1 255",
                        c, bus.out_valid, bus.rate, bus.isi);
            end
         end
      end
      spike = 1'b0;
   endtask

   task automatic test_enable_drop();
      bus.out_ready = 1'b1;
      go_idle();
      bus.out_ready = 1'b0;
      start(8'd1);
      step();
      step();
      checks++;
      if ({bus.out_valid, overrun} !== 2'b11) begin
         errors++;
         $display("FAIL en_ovr: got v=%0b ov=%0b, exp 1 1", bus.out_valid, overrun);
      end
      enable        = 1'b0;
      bus.out_ready = 1'b1;
      step();
      checks++;
      if ({bus.out_valid, busy, overrun} !== 3'b001) begin
         errors++;
         $display("FAIL en_idle: got v=%0b b=%0b ov=%0b, exp 0 0 1",
                  bus.out_valid, busy, overrun);
      end
      start(8'd8);
      checks++;
      if ({busy, overrun} !== 2'b10) begin
         errors++;
         $display("FAIL en_clr: got b=%0b ov=%0b, exp 1 0", busy, overrun);
      end
      for (int c = 1; c <= 5; c++) begin
         spike = (c == 1 || c == 3);
         if (c == 5) enable = 1'b0;
         step();
      end
      checks++;
      if ({bus.out_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL en_drop: got v=%0b b=%0b, exp 0 0", bus.out_valid, busy);
      end
      for (int c = 0; c < 6; c++) step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL en_nores: got v=%0b, exp 0", bus.out_valid);
      end
      start(8'd8);
      for (int c = 1; c <= 8; c++) begin
         spike = (c == 2);
         step();
      end
      spike = 1'b0;
      checks++;
      if ({bus.out_valid, bus.rate, bus.isi, overrun} !== {1'b1, 5'd1, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL en_fresh: got v=%0b r=%0d i=%0d ov=%0b, exp 1 1 0 0",
                  bus.out_valid, bus.rate, bus.isi, overrun);
      end
   endtask

   task automatic test_zero_len();
      bus.out_ready = 1'b1;
      go_idle();
      start(8'd0);
      spike = 1'b1;
      step();
      spike = 1'b0;
      checks++;
      if ({bus.out_valid, bus.rate} !== {1'b1, 5'd1}) begin
         errors++;
         $display("FAIL zero_len: got v=%0b r=%0d, exp 1 1",
                  bus.out_valid, bus.rate);
      end
      step();
      checks++;
      if ({bus.out_valid, bus.rate} !== {1'b1, 5'd0}) begin
         errors++;
         $display("FAIL zero_len2: got v=%0b r=%0d, exp 1 0",
                  bus.out_valid, bus.rate);
      end
   endtask

   initial begin
      test_reset();
      test_rate_isi();
      test_held();
      test_backpressure();
      test_saturation();
      test_enable_drop();
      test_zero_len();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
